lsu: RTL and testbench
======================

# lsu

Load/store unit sitting directly upstream of the CPU's word-addressed data RAM (1024 × 32-bit, combinational read, write on clock edge with write enable). It accepts byte-addressed byte/halfword/word load and store requests from the core over a valid/ready handshake. It issues word accesses to the RAM, performing sign/zero extension on loads and read-modify-write for sub-word stores. It returns one response pulse per request.

## Interface
- RAM_WORDS, 1024, depth of the attached RAM in 32-bit words; informational, used only for the out-of-range assertion in simulation
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; transfer when req_valid && req_ready at posedge clk
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 halfword, 2 word; 3 is treated as word
- req_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend; ignored for stores and words
- req_addr  in  32  byte address, little-endian
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle response pulse; consumer is always ready
- rsp_rdata  out  32  load result, extended; 0 for stores
- rsp_err  out  1  access fault; see Configuration
- ram_a  out  32  RAM word index = {2'b00, addr[31:2]}
- ram_wd  out  32  RAM write data
- ram_we  out  1  RAM write enable
- ram_rd  in  32  RAM read data, combinational from ram_a

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE: req_ready=1. On transfer, latch we/size/unsigned/addr/wdata and set ram_a. Go to ACCESS.
- ACCESS, load: select lane from ram_rd, extend, register into rsp_rdata. Go to RESP.
- ACCESS, word store: ram_we=1, ram_wd=wdata. Go to RESP.
- ACCESS, sub-word store: ram_we=0. Merge wdata into the captured ram_rd at the lane, register as ram_wd. Go to WRITE.
- WRITE: ram_we=1 with the merged word. Go to RESP.
- RESP: rsp_valid=1 for exactly one cycle. Go to IDLE.
- Lane selection: byte uses addr[1:0], bits [8k+7:8k]. Half uses addr[1], bits [16h+15:16h].
- Sub-word merge: only the addressed lane bits change; the other bits keep their prior value.
- rsp_rdata/rsp_err hold their value until the next RESP. rsp_rdata=0 for stores.
- req_ready=0 in every state except IDLE; no request is accepted in RESP.

## Timing
- Transfer at edge T. ram_a is valid in cycle T+1.
- Load and word store: rsp_valid in cycle T+2. Sub-word store: rsp_valid in cycle T+3.
- Word store writes the RAM at edge T+2. Sub-word store writes at edge T+3.
- Earliest next transfer: edge T+3 (load / word store) or T+4 (sub-word store).
- Reset values: req_ready=0 while rst is sampled high, then 1. rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_a=0, ram_wd=0, ram_we=0, state IDLE.
- ram_we is gated by !rst, so no RAM write occurs at any edge where rst is high.
- Reset mid-operation: the in-flight request is dropped with no response and no partial write.
- Out-of-range addr (addr[31:2] >= RAM_WORDS): simulation assertion only; no RTL behaviour is defined.

## Configuration
- MISALIGN_TRAP_EN defined: a misaligned access is a fault.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - The faulting request still follows the ACCESS → RESP path, with ram_we never asserted.
  - rsp_err=1, rsp_rdata=0, response at T+2.
- Undefined: misaligned low bits are ignored.
  - Half uses addr[1] only; word ignores addr[1:0].
  - rsp_err is tied to 0.

## Structure
- Package lsu_pkg:
  - size_e enum (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2).
  - lsu_state_e enum.
  - Function for misalignment detection.
- Sub-module lsu_align, purely combinational:
  - Inputs: size, unsigned, addr[1:0], ram word, store data.
  - Outputs: extended load value and merged store word.
- The top module holds the FSM and registers.

## Test plan
- Word store addr 0x10, wdata 0xDEADBEEF, then word load 0x10 → RAM[4]=0xDEADBEEF at T+2; load rsp_rdata=0xDEADBEEF at T+2.
- Byte store 0xAA to addr 0x11 over 0x11223344 → RAM[4]=0x1122AA44; rsp_valid at T+3.
- Byte load addr 0x13 of 0x80FF0000: signed → 0xFFFFFF80; unsigned → 0x00000080.
- Half load addr 0x12 of 0x8001_1234: signed → 0xFFFF8001; half store 0xBEEF to 0x10 → 0x8001BEEF.
- Word load addr 0x11:
  - With MISALIGN_TRAP_EN: rsp_err=1, rsp_rdata=0, RAM unchanged.
  - Without: returns RAM[4], rsp_err=0.
- rst high during WRITE of a byte store → ram_we stays 0, no rsp_valid, RAM word unchanged, req_ready=1 the cycle after rst falls.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  // Size 3 is handled as a word, so any non-byte, non-half size needs word alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF) begin
      mis = addr_lo[0];
    end else if (size != SZ_BYTE) begin
      mis = (addr_lo != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane select/extend for loads and lane merge for sub-word stores
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        zero_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] ram_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane  = ram_word[{addr_lo, 3'b000} +: 8];
    half_lane  = ram_word[{addr_lo[1], 4'b0000} +: 16];
    load_data  = ram_word;
    merge_data = store_data;
    case (size)
      SZ_BYTE: begin
        load_data  = zero_ext ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        merge_data = ram_word;
        merge_data[{addr_lo, 3'b000} +: 8] = store_data[7:0];
      end
      SZ_HALF: begin
        load_data  = zero_ext ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
        merge_data = ram_word;
        merge_data[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
      end
      default: begin
        load_data  = ram_word;
        merge_data = store_data;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit FSM in front of a word-addressed data RAM
// Optional misaligned-access fault: define MISALIGN_TRAP_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] ram_a,
  output logic [31:0] ram_wd,
  output logic        ram_we,
  input  logic [31:0] ram_rd
);

  lsu_state_e  state;
  logic        we_q;
  logic        uns_q;
  logic        mis_q;
  logic [1:0]  size_q;
  logic [1:0]  lo_q;
  logic [31:0] wdata_q;
  logic        ram_we_q;
  logic        mis_in;
  logic        sub_word;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  lsu_align u_align (
    .size       (size_q),
    .zero_ext   (uns_q),
    .addr_lo    (lo_q),
    .ram_word   (ram_rd),
    .store_data (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

`ifdef MISALIGN_TRAP_EN
  assign mis_in = is_misaligned(req_size, req_addr[1:0]);
`else
  assign mis_in = 1'b0;
`endif

  assign sub_word = (size_q == SZ_BYTE) || (size_q == SZ_HALF);
  // Combinational gate so a reset arriving in a write cycle cannot corrupt the RAM.
  assign ram_we   = ram_we_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      ram_a     <= 32'h0;
      ram_wd    <= 32'h0;
      ram_we_q  <= 1'b0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      mis_q     <= 1'b0;
      size_q    <= 2'b00;
      lo_q      <= 2'b00;
      wdata_q   <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          rsp_valid <= 1'b0;
          ram_we_q  <= 1'b0;
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            lo_q      <= req_addr[1:0];
            wdata_q   <= req_wdata;
            mis_q     <= mis_in;
            ram_a     <= {2'b00, req_addr[31:2]};
            req_ready <= 1'b0;
            state     <= ST_ACCESS;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (mis_q) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (!we_q) begin
            rsp_rdata <= load_data;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (sub_word) begin
            ram_wd    <= merge_data;
            state     <= ST_WRITE;
          end else begin
            ram_wd    <= wdata_q;
            ram_we_q  <= 1'b1;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_WRITE: begin
          ram_we_q  <= 1'b1;
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid <= 1'b0;
          ram_we_q  <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && req_valid && req_ready) begin
      assert ({2'b00, req_addr[31:2]} < RAM_WORDS);
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed-vector bench for lsu with a behavioural 1024x32 RAM
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ram_a;
  logic [31:0] ram_wd;
  logic        ram_we;
  logic [31:0] ram_rd;

  logic [31:0] mem [0:1023];

  int n_vec;
  int n_err;

  lsu #(.RAM_WORDS(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_a        (ram_a),
    .ram_wd       (ram_wd),
    .ram_we       (ram_we),
    .ram_rd       (ram_rd)
  );

  assign ram_rd = mem[ram_a[9:0]];

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_a[9:0]] <= ram_wd;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
    int k;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat   = 0;
    rdata = 32'h0;
    err   = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) check("ram_a", ram_a, {2'b00, addr[31:2]});
      if (rsp_valid) begin
        lat   = c;
        rdata = rsp_rdata;
        err   = rsp_err;
        break;
      end
    end
    if (lat == 0) check("rsp_timeout", 32'(lat), 32'd2);
    @(negedge clk);
    check("rsp_pulse", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lt;
    bit          saw_rsp;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_ram_a", ram_a, 32'h0);
    check("rst_ram_wd", ram_wd, 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // word store then word load
    xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lt);
    check("sw_lat", 32'(lt), 32'd2);
    check("sw_rdata", rd, 32'h0);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lt);
    check("lw_lat", 32'(lt), 32'd2);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", 32'(er), 32'd0);

    // byte store merge
    xact(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, rd, er, lt);
    xact(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, rd, er, lt);
    check("sb_lat", 32'(lt), 32'd3);
    check("sb_rdata", rd, 32'h0);
    check("sb_mem", mem[4], 32'h1122AA44);

    // byte loads, signed and unsigned
    xact(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF0000, rd, er, lt);
    xact(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, er, lt);
    check("lb_rdata", rd, 32'hFFFFFF80);
    check("lb_lat", 32'(lt), 32'd2);
    xact(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er, lt);
    check("lbu_rdata", rd, 32'h00000080);
    xact(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, rd, er, lt);
    check("lb2_rdata", rd, 32'hFFFFFFFF);

    // half loads and half store
    xact(1'b1, 2'd2, 1'b0, 32'h10, 32'h80011234, rd, er, lt);
    xact(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd, er, lt);
    check("lh_rdata", rd, 32'hFFFF8001);
    xact(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd, er, lt);
    check("lhu_rdata", rd, 32'h00008001);
    xact(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, rd, er, lt);
    check("lh_lo_rdata", rd, 32'h00001234);
    xact(1'b1, 2'd1, 1'b0, 32'h10, 32'h1234BEEF, rd, er, lt);
    check("sh_lat", 32'(lt), 32'd3);
    check("sh_mem", mem[4], 32'h8001BEEF);

    // size 3 behaves as word
    xact(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, rd, er, lt);
    check("l3_rdata", rd, 32'h8001BEEF);

    // misaligned word load and store
    xact(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, rd, er, lt);
    check("lw_mis_lat", 32'(lt), 32'd2);
`ifdef MISALIGN_TRAP_EN
    check("lw_mis_err", 32'(er), 32'd1);
    check("lw_mis_rdata", rd, 32'h0);
`else
    check("lw_mis_err", 32'(er), 32'd0);
    check("lw_mis_rdata", rd, 32'h8001BEEF);
`endif
    xact(1'b1, 2'd2, 1'b0, 32'h12, 32'h5555AAAA, rd, er, lt);
    check("sw_mis_lat", 32'(lt), 32'd2);
`ifdef MISALIGN_TRAP_EN
    check("sw_mis_err", 32'(er), 32'd1);
    check("sw_mis_mem", mem[4], 32'h8001BEEF);
`else
    check("sw_mis_err", 32'(er), 32'd0);
    check("sw_mis_mem", mem[4], 32'h5555AAAA);
`endif

    // reset during the write phase of a byte store
    xact(1'b1, 2'd2, 1'b0, 32'h20, 32'h01020304, rd, er, lt);
    saw_rsp = 1'b0;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h21;
    req_wdata    = 32'h000000FF;
    check("rw_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    if (rsp_valid) saw_rsp = 1'b1;
    @(negedge clk);
    if (rsp_valid) saw_rsp = 1'b1;
    rst = 1'b1;
    check("rw_we_in_rst", 32'(ram_we), 32'd0);
    @(negedge clk);
    if (rsp_valid) saw_rsp = 1'b1;
    check("rw_we_after", 32'(ram_we), 32'd0);
    check("rw_ready_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    if (rsp_valid) saw_rsp = 1'b1;
    check("rw_ready_after", 32'(req_ready), 32'd1);
    check("rw_no_rsp", 32'(saw_rsp), 32'd0);
    check("rw_mem", mem[8], 32'h01020304);
    xact(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lt);
    check("rw_reload", rd, 32'h01020304);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
